inst_prefetch_fetch: RTL
========================

// Module: inst_prefetch_fetch
// PURPOSE
//  Instruction fetch stage directly upstream of the multi-cycle core.
//  Accepts a one-cycle fetch_order with the current pc and returns one
//  instruction word with a one-cycle fetched pulse.
//  Reads the synchronous instruction BRAM, then prefetches the next
//  sequential word into a one-entry buffer. Straight-line code therefore
//  hits with 1-cycle latency instead of a full BRAM round trip.
// PARAMETERS
//  PC_W    32  width of pc from the core (byte address)
//  IADDR_W 15  instruction BRAM word-address width (matches LEN_MEMISTR_ADDR)
//  RD_LAT  1   BRAM read latency in cycles, >=1: a_inst is sampled by BRAM, d_inst is valid RD_LAT cycles later
// PORTS
//  clk          in   1        clock, all state updates on posedge
//  rst          in   1        asynchronous, active-high reset
//  fetch_order  in   1        one-cycle request strobe from core
//  pc           in   PC_W     request byte address; sampled only when fetch_order=1
//  inv          in   1        invalidate buffer and abort any prefetch (program loader wrote BRAM)
//  fetched      out  1        one-cycle pulse: inst is valid for the last order
//  inst         out  32       fetched instruction; held stable until the next fetched pulse
//  a_inst       out  IADDR_W  BRAM word address, registered
//  d_inst       in   32       BRAM read data
// BEHAVIOUR
//  Reset (async, rst=1):
//   - fetched=0, inst=0, a_inst=0, buf_valid=0, state=IDLE.
//   - Reset mid-operation abandons any read or prefetch; no fetched pulse follows.
//  Address: word = pc[IADDR_W+1:2]; pc[1:0] ignored; upper pc bits ignored.
//  Next-word arithmetic: word+1 modulo 2^IADDR_W, so max word wraps to 0.
//  Buffer: buf_valid, buf_addr[IADDR_W], buf_data[32].
//  States and transitions:
//   - IDLE:
//     - order with buf_valid and buf_addr==word is a HIT: inst<=buf_data, fetched=1 in the next cycle, then go to PREFETCH of word+1.
//     - Any other order is a MISS: a_inst<=word, go to READ.
//   - READ: wait RD_LAT cycles after a_inst update, then capture d_inst.
//     - Set inst, buf_addr=word, buf_data, buf_valid=1.
//     - fetched=1 in the following cycle; go to PREFETCH.
//     - Orders arriving in READ are a protocol violation: ignored, no response.
//   - PREFETCH: a_inst<=word+1, buf_valid=0; capture RD_LAT cycles later into the buffer (buf_valid=1), then go to IDLE.
//     - Order with word==prefetch address: keep waiting; when data lands, deliver it as inst with fetched=1 the next cycle.
//     - Order with any other word: abort prefetch, treat as MISS (a_inst<=word, go to READ). Aborted data is discarded.
//  Latency (order sampled in cycle 0):
//   - hit: fetched in cycle 1.
//   - miss: a_inst valid in cycle 1, fetched in cycle RD_LAT+2.
//  Simultaneous events:
//   - Order in the same cycle a prefetch lands is compared against the landing address and data.
//   - inv has priority over everything: clears buf_valid and aborts PREFETCH. An order in the same cycle as inv is a MISS.
//   - inv during READ: the READ completes, but its data is not kept in the buffer.
//  fetched never asserts on two consecutive cycles. inst changes only with fetched.
// TESTING (RD_LAT=1; mem[0]=0x00000013, mem[1]=0x00100093, mem[0x40]=0xDEADBEEF)
//  1. rst pulse, then order pc=0 in cycle 0 -> a_inst=0 in cycle 1, fetched=1 and inst=0x00000013 in cycle 3, a_inst=1 next.
//  2. After the prefetch lands, order pc=4 -> fetched the next cycle, inst=0x00100093, then a_inst=2.
//  3. Order pc=4 the cycle after test 1's fetched (prefetch in flight) -> fetched when the prefetch lands (<= cycle 3), inst=0x00100093.
//  4. Order pc=0x100 during the prefetch of word 1 -> a_inst=0x40, fetched at miss latency, inst=0xDEADBEEF, no hit on word 1.
//  5. Order pc=(2^IADDR_W-1)*4 -> prefetch a_inst=0; then order pc=0 -> hit in 1 cycle.
//  6. inv with a matching order in the same cycle -> miss latency. rst asserted in READ -> fetched stays 0, inst=0, a_inst=0.

Source files
------------

// File: rtl/inst_prefetch_fetch.sv
// -----------------------------------------------------------------------------
// inst_prefetch_fetch
//   Instruction fetch stage in front of the multi-cycle core. A one-cycle
//   fetch_order with a byte pc returns one 32-bit instruction with a one-cycle
//   fetched pulse. After every delivered word, the next sequential word is
//   prefetched from the synchronous instruction BRAM into a one-entry buffer.
//   Straight-line code then hits with 1-cycle latency.
//
// Ports
//   clk          in   1        clock, all state updates on posedge
//   rst          in   1        asynchronous, active-high reset
//   fetch_order  in   1        one-cycle request strobe from the core
//   pc           in   PC_W     request byte address, sampled with fetch_order
//   inv          in   1        invalidate buffer / abort prefetch (BRAM rewritten)
//   fetched      out  1        one-cycle pulse: inst answers the last order
//   inst         out  32       fetched instruction, held until the next pulse
//   a_inst       out  IADDR_W  registered BRAM word address
//   d_inst       in   32       BRAM read data, valid RD_LAT cycles after a_inst
// -----------------------------------------------------------------------------
module inst_prefetch_fetch #(
  parameter int PC_W    = 32,
  parameter int IADDR_W = 15,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_order,
  input  logic [PC_W-1:0]    pc,
  input  logic               inv,
  output logic               fetched,
  output logic [31:0]        inst,
  output logic [IADDR_W-1:0] a_inst,
  input  logic [31:0]        d_inst
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

  typedef enum logic [1:0] {IDLE, READ, PREFETCH} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic                 pending;    // order waiting for the in-flight prefetch
  logic                 inv_seen;   // inv arrived while the current READ was open
  logic                 buf_valid;
  logic [IADDR_W-1:0]   buf_addr;
  logic [31:0]          buf_data;
  logic [IADDR_W-1:0]   req_word;   // word being read in READ
  logic [IADDR_W-1:0]   pf_addr;    // word being prefetched in PREFETCH

  logic [IADDR_W-1:0]   word;
  logic                 hit;
  logic                 pf_match;
  logic                 data_due;   // d_inst carries the requested word this cycle

  // Control strobes decoded from state and inputs
  logic                 do_miss;
  logic [IADDR_W-1:0]   miss_addr;
  logic                 do_fetch;
  logic [31:0]          fetch_data;
  logic                 do_pf;
  logic [IADDR_W-1:0]   pf_base;
  logic [IADDR_W-1:0]   pf_next;
  logic                 buf_fill;
  logic                 buf_clr;
  logic                 set_pending;

  // Only the word-address bits of pc matter; byte offset and high bits are dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[PC_W-1:IADDR_W+2], pc[1:0]};

  assign word     = pc[IADDR_W+1:2];
  assign hit      = fetch_order && !inv && buf_valid && (buf_addr == word);
  assign pf_match = (word == pf_addr);
  assign data_due = (cnt == CNT_LAST);
  assign pf_next  = pf_base + IADDR_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (fetch_order) state_n = hit ? PREFETCH : READ;
      end
      READ: begin
        if (data_due) state_n = (inv_seen || inv) ? IDLE : PREFETCH;
      end
      PREFETCH: begin
        if (inv) begin
          state_n = (fetch_order || pending) ? READ : IDLE;
        end else if (fetch_order && !pending && !pf_match) begin
          state_n = READ;
        end else if (data_due) begin
          state_n = (pending || (fetch_order && pf_match)) ? PREFETCH : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    do_miss     = 1'b0;
    miss_addr   = word;
    do_fetch    = 1'b0;
    fetch_data  = d_inst;
    do_pf       = 1'b0;
    pf_base     = word;
    buf_fill    = 1'b0;
    buf_clr     = inv;
    set_pending = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_order) begin
          if (hit) begin
            do_fetch   = 1'b1;
            fetch_data = buf_data;
            do_pf      = 1'b1;
          end else begin
            do_miss = 1'b1;
          end
        end
      end
      READ: begin
        if (data_due) begin
          do_fetch = 1'b1;
          if (inv_seen || inv) begin
            buf_clr = 1'b1;
          end else begin
            do_pf   = 1'b1;
            pf_base = req_word;
          end
        end
      end
      PREFETCH: begin
        if (inv) begin
          // A waiting order must still be answered, so re-read its word.
          if (pending) begin
            do_miss   = 1'b1;
            miss_addr = pf_addr;
          end else if (fetch_order) begin
            do_miss = 1'b1;
          end
        end else if (fetch_order && !pending && !pf_match) begin
          do_miss = 1'b1;
        end else if (data_due) begin
          if (pending || (fetch_order && pf_match)) begin
            do_fetch = 1'b1;
            do_pf    = 1'b1;
            pf_base  = pf_addr;
          end else begin
            buf_fill = 1'b1;
          end
        end else if (fetch_order && !pending) begin
          set_pending = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched   <= 1'b0;
      inst      <= '0;
      a_inst    <= '0;
      buf_valid <= 1'b0;
      cnt       <= '0;
      pending   <= 1'b0;
      inv_seen  <= 1'b0;
    end else begin
      fetched <= do_fetch;
      if (do_fetch) inst <= fetch_data;

      if (do_miss)    a_inst <= miss_addr;
      else if (do_pf) a_inst <= pf_next;

      if (do_miss || do_pf)   cnt <= '0;
      else if (!data_due)     cnt <= cnt + CNT_W'(1);

      if (buf_clr || do_pf)   buf_valid <= 1'b0;
      else if (buf_fill)      buf_valid <= 1'b1;

      if (set_pending)                        pending <= 1'b1;
      else if (do_miss || do_fetch || do_pf)  pending <= 1'b0;

      if (do_miss)                            inv_seen <= 1'b0;
      else if (state == READ && inv)          inv_seen <= 1'b1;
    end
  end

  // Address/data holding registers; qualified by the control state above.
  always_ff @(posedge clk) begin
    if (do_miss) req_word <= miss_addr;
    if (do_pf)   pf_addr  <= pf_next;
    if (buf_fill) begin
      buf_addr <= pf_addr;
      buf_data <= d_inst;
    end
  end

endmodule
